// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared enums and helpers for the UART link core
package uart_link_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    // Cycles per 16x oversample tick, never below one
    function automatic int baud_div(input int clock_freq, input int baud_rate);
        int d;
        d = clock_freq / (16 * baud_rate);
        return (d < 1) ? 1 : d;
    endfunction

    // Parity bit that makes the frame even/odd; payload is zero-extended to 9 bits
    function automatic logic parity_bit(input parity_e p, input logic [8:0] d);
        return (p == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO, power-of-two depth, wrapping pointers
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Next pointer, occupancy and storage contents
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    // Storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_link_core.sv
// uart_link_core: full-duplex UART with 16x oversampled receiver, RX FIFO and activity indicator
module uart_link_core
    import uart_link_pkg::*;
#(
    parameter int      CLOCK_FREQ      = 50_000_000,
    parameter int      BAUD_RATE       = 9600,
    parameter int      DATA_BITS       = 8,
    parameter parity_e PARITY          = PAR_NONE,
    parameter int      RX_FIFO_DEPTH   = 16,
    parameter int      ACTIVITY_CYCLES = 5_000_000
) (
    input  logic                           clk_50mhz,
    input  logic                           reset_n,
    input  logic                           uart_rx,
    output logic                           uart_tx,
    input  logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic [DATA_BITS-1:0]           rx_data,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic [$clog2(RX_FIFO_DEPTH):0] rx_fifo_count,
    output logic                           rx_overrun,
    output logic                           rx_frame_err,
    output logic                           rx_parity_err,
    input  logic                           err_clear,
    output logic                           link_active
);

    localparam int DIV = baud_div(CLOCK_FREQ, BAUD_RATE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(ACTIVITY_CYCLES + 1);

    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [1:0]           sync_q, sync_d;
    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_tick_q, rx_tick_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_bad_q, rx_bad_d, push_q, push_d, perr_q, perr_d, ferr_q, ferr_d;
    tx_state_e            tx_state_q, tx_state_d;
    logic [3:0]           tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_line_q, tx_line_d;
    logic                 ovr_q, ovr_d;
    logic [CW-1:0]        act_q, act_d;
    logic                 tick, rx_s, rx_sample, tx_done, accept, pop, fifo_full, fifo_empty;

    assign tick      = (tick_cnt_q == TW'(DIV - 1));
    assign rx_s      = sync_q[1];
    assign rx_sample = tick && (rx_tick_q == 4'd15);
    assign tx_done   = tick && (tx_tick_q == 4'd15);
    assign tx_ready  = (tx_state_q == TX_IDLE);
    assign accept    = tx_valid && tx_ready;
    assign rx_valid  = !fifo_empty;
    assign pop       = rx_valid && rx_ready;

    uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_fifo (
        .clk       (clk_50mhz),
        .rst_n     (reset_n),
        .push      (push_q),
        .push_data (rx_shift_q),
        .pop       (pop),
        .head      (rx_data),
        .count     (rx_fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Oversample tick divider and input synchronizer
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        sync_d     = {sync_q[0], uart_rx};
    end

    // Receiver: start validation at mid-bit, then one sample every 16 ticks
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = tick ? rx_tick_q + 4'd1 : rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_bad_d   = rx_bad_q;
        push_d     = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_bad_d   = 1'b0;
                end
            end
            RX_START: if (tick && rx_tick_q == 4'd7) begin
                rx_tick_d  = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_sample) begin
                rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
                if (rx_bit_q == 4'(DATA_BITS - 1))
                    rx_state_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
            end
            RX_PARITY: if (rx_sample) begin
                if (rx_s != parity_bit(PARITY, 9'(rx_shift_q))) begin
                    perr_d   = 1'b1;
                    rx_bad_d = 1'b1;
                end
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_sample) begin
                if (rx_s) begin
                    push_d     = !rx_bad_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    ferr_d     = 1'b1;
                    rx_state_d = RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: if (rx_s) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Transmitter: registered line output, each frame bit held for 16 ticks
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tick ? tx_tick_q + 4'd1 : tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_tick_d = '0;
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_par_d   = parity_bit(PARITY, 9'(tx_data));
                end
            end
            TX_START: if (tx_done) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
            end
            TX_DATA: if (tx_done) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'(DATA_BITS - 1))
                    tx_state_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
            end
            TX_PARITY: if (tx_done) tx_state_d = TX_STOP;
            TX_STOP:   if (tx_done) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
        tx_line_d = (tx_state_d == TX_START)  ? 1'b0 :
                    (tx_state_d == TX_DATA)   ? tx_shift_d[0] :
                    (tx_state_d == TX_PARITY) ? tx_par_d : 1'b1;
    end

    // Sticky overrun (set beats clear) and retriggerable activity stretcher
    always_comb begin
        ovr_d = (push_q && fifo_full && !pop) ? 1'b1 : (err_clear ? 1'b0 : ovr_q);
        act_d = (push_q || accept) ? CW'(ACTIVITY_CYCLES) :
                (act_q != '0)      ? act_q - 1'b1 : act_q;
    end

    // State registers; synchronizer resets high so reset release is not a start bit
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_bad_q   <= 1'b0;
            push_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            ovr_q      <= 1'b0;
            act_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_bad_q   <= rx_bad_d;
            push_q     <= push_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            ovr_q      <= ovr_d;
            act_q      <= act_d;
        end
    end

    assign uart_tx       = tx_line_q;
    assign rx_overrun    = ovr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_parity_err = perr_q;
    assign link_active   = (act_q != '0);

endmodule
